// File: rtl/logsoftmax_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module : logsoftmax_row_sequencer
// Three-pass (max / sum / out) control sequencer for the row-wise LogSoftmax datapath.
// Rev    : 1.0
// ============================================================================
module logsoftmax_row_sequencer #(
   parameter int ROW_LEN = 1024,
   parameter int ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   row_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [1:0]        phase,
   output logic              acc_clr,
   output logic              acc_en,
   output logic              lse_req,
   input  logic              lse_ack,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_MAX       = 3'd1,
      S_MAX_DRAIN = 3'd2,
      S_SUM       = 3'd3,
      S_SUM_DRAIN = 3'd4,
      S_LOG       = 3'd5,
      S_OUT       = 3'd6,
      S_DONE      = 3'd7
   } state_t;

   localparam logic [1:0]      PH_IDLE   = 2'd0;
   localparam logic [1:0]      PH_MAX    = 2'd1;
   localparam logic [1:0]      PH_SUM    = 2'd2;
   localparam logic [1:0]      PH_OUT    = 2'd3;
   localparam logic [ADDR_W:0] C_ROW_LEN = (ADDR_W+1)'(ROW_LEN);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pend_q, pend_d;
   logic              acc_clr_q, acc_clr_d;
   logic              acc_en_q, acc_en_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              lse_req_q, lse_req_d;
   logic [1:0]        phase_q, phase_d;

   logic              w_rd_issue;
   logic              w_hs;
   logic              w_at_last;
   logic              w_len_ok;
   logic [ADDR_W:0]   w_len_m1;

   // pend_q marks "addresses remain"; in OUT the strobe is additionally gated
   // by output-stage space so a held element is never overwritten.
   assign w_rd_issue = pend_q && (!out_valid_q || out_ready);
   assign w_hs       = out_valid_q && out_ready;
   assign w_at_last  = (addr_q == last_q);
   assign w_len_ok   = (row_len != '0) && (row_len <= C_ROW_LEN);
   assign w_len_m1   = row_len - (ADDR_W+1)'(1);

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      addr_d      = addr_q;
      pend_d      = pend_q;
      acc_clr_d   = 1'b0;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      acc_en_d    = w_rd_issue && ((state_q == S_MAX) || (state_q == S_SUM));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_len_ok) begin
                  last_d    = w_len_m1[ADDR_W-1:0];
                  addr_d    = '0;
                  pend_d    = 1'b1;
                  acc_clr_d = 1'b1;
                  err_d     = 1'b0;
                  state_d   = S_MAX;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_MAX, S_SUM: begin
            if (w_at_last) begin
               pend_d  = 1'b0;
               state_d = (state_q == S_MAX) ? S_MAX_DRAIN : S_SUM_DRAIN;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         S_MAX_DRAIN: begin
            addr_d    = '0;
            pend_d    = 1'b1;
            acc_clr_d = 1'b1;
            state_d   = S_SUM;
         end
         S_SUM_DRAIN: state_d = S_LOG;
         S_LOG: begin
            if (lse_ack) begin
               addr_d  = '0;
               pend_d  = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (w_rd_issue) begin
               out_valid_d = 1'b1;
               out_last_d  = w_at_last;
               if (w_at_last) pend_d = 1'b0;
               else           addr_d = addr_q + ADDR_W'(1);
            end else if (w_hs) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end
            if (w_hs && out_last_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status strobes are decoded from the next state so they register alongside it.
      busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d    = (state_d == S_DONE);
      lse_req_d = (state_d == S_LOG);
      case (state_d)
         S_MAX, S_MAX_DRAIN:        phase_d = PH_MAX;
         S_SUM, S_SUM_DRAIN, S_LOG: phase_d = PH_SUM;
         S_OUT:                     phase_d = PH_OUT;
         default:                   phase_d = PH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_q      <= '0;
         addr_q      <= '0;
         pend_q      <= 1'b0;
         acc_clr_q   <= 1'b0;
         acc_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lse_req_q   <= 1'b0;
         phase_q     <= PH_IDLE;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         pend_q      <= pend_d;
         acc_clr_q   <= acc_clr_d;
         acc_en_q    <= acc_en_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         lse_req_q   <= lse_req_d;
         phase_q     <= phase_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rd_en     = w_rd_issue;
   assign rd_addr   = addr_q;
   assign phase     = phase_q;
   assign acc_clr   = acc_clr_q;
   assign acc_en    = acc_en_q;
   assign lse_req   = lse_req_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_logsoftmax_row_sequencer.sv
`default_nettype none
// Bench for logsoftmax_row_sequencer: row vector table, output scoreboard and
// hand-written reset / busy-start sequences.
module tb_logsoftmax_row_sequencer;
   localparam int ROW_LEN = 1024;
   localparam int ADDR_W  = 10;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              start     = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W:0]   row_len   = '0;
   logic              busy, done, err, rd_en, acc_clr, acc_en, lse_req, lse_ack;
   logic              out_valid, out_last;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        phase;

   int                cyc     = 0;
   int                req_cyc = 0;
   int                ack_dly = 0;
   logic [ADDR_W-1:0] rd_data_addr = '0;
   int                checks = 0;
   int                errors = 0;
   int                sb[$];

   typedef struct {
      int len;
      int ack_d;
      int rmode;
      bit err;
      int done_exp;
      bit disturb;
   } vec_t;
   vec_t tbl[9];

   logsoftmax_row_sequencer #(.ROW_LEN(ROW_LEN), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .row_len(row_len),
      .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
      .phase(phase), .acc_clr(acc_clr), .acc_en(acc_en), .lse_req(lse_req),
      .lse_ack(lse_ack), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) req_cyc <= lse_req ? req_cyc + 1 : 0;
   // Row-buffer model: data word is its own address, held while rd_en is low.
   always @(posedge clk) if (rd_en) rd_data_addr <= rd_addr;
   assign lse_ack = lse_req && (req_cyc >= ack_dly);

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctrl"}, {busy, done, err, rd_en, acc_clr, acc_en, lse_req, out_valid, out_last}, 0);
      chk({name, "_addr"}, rd_addr, 0);
      chk({name, "_phase"}, phase, 0);
   endtask

   task automatic run_row(input int len, input int ack_d, input int rmode,
                          input bit exp_err, input int exp_done, input bit disturb);
      int t0, rel, done_t, clr_n, clr_t0, clr_t1, req_t, req_n, ov_t, last_hs, budget, rd_tot, e;
      int nxt[4];
      int rds[4];
      bit p_rd, p_acc_ph, p_ov, p_rdy, p_last, p_req, p_ack;
      logic [ADDR_W-1:0] p_data;
      done_t = -1; clr_n = 0; clr_t0 = -1; clr_t1 = -1; req_t = -1; req_n = 0;
      ov_t = -1; last_hs = -1; rd_tot = 0;
      for (int i = 0; i < 4; i++) begin nxt[i] = 0; rds[i] = 0; end
      p_rd = 0; p_acc_ph = 0; p_ov = 0; p_rdy = 0; p_last = 0; p_req = 0; p_ack = 0;
      p_data = '0;
      budget = exp_err ? 40 : 6 * len + ack_d + 40;
      sb.delete();
      if (!exp_err) for (int i = 0; i < len; i++) sb.push_back(i);
      ack_dly = ack_d;
      @(posedge clk); #1;
      start = 1'b1; row_len = (ADDR_W+1)'(len); t0 = cyc;
      for (int k = 0; k < budget && done_t < 0; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (disturb) begin
            if (k == 2 || k == 9) begin start = 1'b1; row_len = 2; end
            if (k == 6) row_len = 9;
         end
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         rel = cyc - t0;
         if (!exp_err && !done) chk("busy", busy, 1);
         if (rd_en) begin
            rd_tot++;
            chk("rd_phase_nonzero", phase != 2'd0, 1);
            if (phase != 2'd0) begin
               chk("rd_addr", rd_addr, nxt[phase]);
               nxt[phase]++;
               rds[phase]++;
            end
         end
         chk("acc_en", acc_en, p_rd && p_acc_ph);
         if (acc_clr) begin
            if (clr_n == 0) clr_t0 = rel; else clr_t1 = rel;
            clr_n++;
         end
         if (lse_req) begin
            if (req_n == 0) req_t = rel;
            req_n++;
         end
         if (p_req && p_ack) chk("lse_req_after_ack", lse_req, 0);
         if (p_ov && !p_rdy) begin
            chk("out_valid_hold", out_valid, 1);
            chk("data_hold", rd_data_addr, p_data);
            chk("out_last_hold", out_last, p_last);
         end
         if (out_valid && ov_t < 0) ov_t = rel;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("out_addr", rd_data_addr, e);
               chk("out_last", out_last, e == len - 1);
            end
            last_hs = rel;
         end
         if (done) begin
            done_t = rel;
            chk("done_busy", busy, 0);
            chk("done_phase", phase, 0);
            chk("done_err", err, exp_err);
         end
         p_rd = rd_en; p_acc_ph = (phase == 2'd1) || (phase == 2'd2);
         p_ov = out_valid; p_rdy = out_ready; p_last = out_last; p_data = rd_data_addr;
         p_req = lse_req; p_ack = lse_ack;
      end
      chk("done_seen", done_t >= 0, 1);
      if (exp_err) begin
         chk("err_no_reads", rd_tot, 0);
         chk("err_done_cycle", done_t, 1);
         chk("err_no_output", ov_t, -1);
      end else begin
         chk("reads_max", rds[1], len);
         chk("reads_sum", rds[2], len);
         chk("reads_out", rds[3], len);
         chk("acc_clr_count", clr_n, 2);
         chk("acc_clr_first", clr_t0, 1);
         chk("acc_clr_second", clr_t1, len + 2);
         chk("lse_req_cycle", req_t, 2 * len + 3);
         chk("lse_req_len", req_n, ack_d + 1);
         chk("first_out_valid", ov_t, 2 * len + 5 + ack_d);
         chk("done_after_last", done_t, last_hs + 1);
         chk("sb_drained", sb.size(), 0);
         if (exp_done >= 0) chk("done_cycle", done_t, exp_done);
      end
      repeat (2) @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("err_held", err, exp_err);
   endtask

   initial begin
      tbl[0] = '{4,    0, 0, 1'b0, 17,   1'b0};
      tbl[1] = '{1,    0, 0, 1'b0, 8,    1'b0};
      tbl[2] = '{0,    0, 0, 1'b1, 1,    1'b0};
      tbl[3] = '{1025, 0, 0, 1'b1, 1,    1'b0};
      tbl[4] = '{3,    2, 0, 1'b0, 16,   1'b0};
      tbl[5] = '{8,    5, 1, 1'b0, -1,   1'b0};
      tbl[6] = '{6,    1, 2, 1'b0, -1,   1'b0};
      tbl[7] = '{5,    0, 0, 1'b0, 20,   1'b1};
      tbl[8] = '{1024, 0, 0, 1'b0, 3077, 1'b0};

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_all_zero("idle");

      for (int v = 0; v < 9; v++)
         run_row(tbl[v].len, tbl[v].ack_d, tbl[v].rmode, tbl[v].err, tbl[v].done_exp, tbl[v].disturb);

      // Reset in the middle of the SUM pass of a 16-element row.
      ack_dly = 0;
      @(posedge clk); #1;
      start = 1'b1; row_len = 16; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int w = 0; w < 60 && phase != 2'd2; w++) begin @(posedge clk); #1; end
      chk("reach_sum", phase, 2);
      chk("sum_reading", rd_en, 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      repeat (2) @(negedge clk);
      chk_all_zero("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
      run_row(2, 0, 0, 1'b0, 11, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/logsoftmax_row_sequencer.md
Name: logsoftmax_row_sequencer

Overview:
Control sequencer for the row-wise LogSoftmax datapath. It runs three passes over one row held in an on-chip row buffer:
- MAX pass: running maximum.
- SUM pass: sum of exp(x - max).
- OUT pass: x - max - log(sum), streamed out.

Between SUM and OUT it performs a req/ack handshake with the shared log unit. It owns the row-buffer read port and all datapath control strobes; the arithmetic lives in the datapath.

Parameters:
ROW_LEN, 1024, maximum row length supported
ADDR_W, 10, row-buffer address width (clog2(ROW_LEN))

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin processing one row; sampled only in IDLE
row_len  input  ADDR_W+1  elements in row; latched when start is accepted
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at end of row (normal or error)
err  output  1  row_len invalid; valid with done, held until next start
rd_en  output  1  row-buffer read strobe
rd_addr  output  ADDR_W  row-buffer read address
phase  output  2  datapath mode: 0 idle, 1 max, 2 sum, 3 out
acc_clr  output  1  clear datapath accumulator; one pulse at the first cycle of the MAX and SUM passes
acc_en  output  1  rd_en delayed 1 cycle during MAX/SUM: read data valid for accumulation
lse_req  output  1  request log(sum) from the log unit
lse_ack  input  1  log unit finished; result latched by datapath
out_valid  output  1  output element valid
out_last  output  1  with out_valid, marks element row_len-1
out_ready  input  1  downstream accepts output

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: busy, done, err, rd_en, rd_addr, phase, acc_clr, acc_en, lse_req, out_valid, out_last. All outputs are registered.
- Row buffer has 1-cycle read latency and holds rd_data while rd_en=0.
- States: IDLE, MAX, MAX_DRAIN, SUM, SUM_DRAIN, LOG, OUT, DONE.
- IDLE:
  - start=1 with 1<=row_len<=ROW_LEN: latch len, clear err, go to MAX, busy=1.
  - start=1 with row_len=0 or >ROW_LEN: go to DONE with err=1; no reads issued.
- MAX / SUM:
  - rd_en=1 every cycle; rd_addr counts 0..len-1.
  - acc_clr=1 in the addr-0 cycle.
  - After issuing len-1, go to the _DRAIN state for one cycle (rd_en=0) so the final acc_en beat lands.
  - MAX_DRAIN goes to SUM; SUM_DRAIN goes to LOG.
  - phase=1 in MAX/MAX_DRAIN; phase=2 in SUM/SUM_DRAIN.
- LOG:
  - phase=2; lse_req=1 and held until lse_ack=1 is sampled.
  - lse_req drops the cycle after ack; then go to OUT.
  - lse_ack outside LOG is ignored.
- OUT (phase=3):
  - Read issued when (!out_valid || out_ready) and addresses remain.
  - out_valid is set the cycle after a read issue. It is cleared on handshake (out_valid && out_ready) when no new read was issued that cycle.
  - out_valid, once high, stays high until accepted. Data must not change while waiting.
  - out_last=1 with the element at addr len-1.
  - Handshake on out_last: go to DONE.
- DONE: done=1 for one cycle, busy=0 from the DONE cycle onward, phase=0; then IDLE.
- start while busy is ignored.
- len=1 is legal; each pass issues exactly one read.
- Latency with out_ready=1 and lse_ack returned in the same cycle as lse_req: start sampled at cycle 0 gives done at cycle 3*len+5.
- Reset mid-row: immediate return to IDLE, all outputs 0, no done pulse; the next start begins cleanly.
- Address counter never exceeds len-1; no wrap.

Test Plan:
1. row_len=4, out_ready=1, lse_ack tied to lse_req:
   - rd_addr sequence 0,1,2,3 in each of three passes.
   - acc_clr at cycles 1 and 6.
   - lse_req at cycle 11.
   - out_valid cycles 13-16 with out_last at 16.
   - done at cycle 17; err=0.
2. row_len=1 -> one read per pass; done at cycle 8; out_last coincides with the single out_valid.
3. row_len=0, then row_len=ROW_LEN+1 -> done pulse the cycle after start with err=1; rd_en never asserted.
4. row_len=8, out_ready toggling 1,0,0,1,... and lse_ack delayed 5 cycles:
   - lse_req held exactly until ack.
   - No output dropped or duplicated; addresses 0..7 in order.
   - out_valid never drops without a handshake.
5. Reset asserted during SUM of a row_len=16 row -> all outputs 0 asynchronously. A following row_len=2 row completes normally with done at cycle 11.
6. start pulsed during busy -> ignored; row_len changed mid-row -> latched length still governs (row_len=5 latched gives 5 reads per pass).
